// File: rtl/shiftrows_mixcols_ark.sv
// AES round back-end: ShiftRows, optional MixColumns and AddRoundKey feeding a
// 2-entry valid/ready output queue with a sticky overrun flag.
module shiftrows_mixcols_ark #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        last_round,
  input  logic [31:0] cin0,
  input  logic [31:0] cin1,
  input  logic [31:0] cin2,
  input  logic [31:0] cin3,
  input  logic [31:0] rkey0,
  input  logic [31:0] rkey1,
  input  logic [31:0] rkey2,
  input  logic [31:0] rkey3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout0,
  output logic [31:0] dout1,
  output logic [31:0] dout2,
  output logic [31:0] dout3,
  output logic        drop_err
);

  localparam int unsigned COL_W = 32;
  localparam int unsigned NCOL  = 4;
  localparam int unsigned CNT_W = 2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    // 3a = xtime(a) ^ a
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  logic [NCOL-1:0][COL_W-1:0] cin_p;
  logic [NCOL-1:0][COL_W-1:0] rkey_p;
  logic [NCOL-1:0][COL_W-1:0] sr_p;
  logic [NCOL-1:0][COL_W-1:0] res_p;

  assign cin_p  = {cin3, cin2, cin1, cin0};
  assign rkey_p = {rkey3, rkey2, rkey1, rkey0};

  // Round datapath on the offered input
  always_comb begin
    sr_p  = '0;
    res_p = '0;
    for (int c = 0; c < NCOL; c++) begin
      for (int r = 0; r < NCOL; r++) begin
        sr_p[c][8*(3-r) +: 8] = cin_p[2'(c + r)][8*(3-r) +: 8];
      end
      res_p[c] = (last_round ? sr_p[c] : mix_col(sr_p[c])) ^ rkey_p[c];
    end
  end

  logic [NCOL-1:0][COL_W-1:0] mem [QDEPTH];
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       push;
  logic                       pop;

  assign in_ready  = (count != CNT_W'(QDEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign dout0 = mem[rd_ptr][0];
  assign dout1 = mem[rd_ptr][1];
  assign dout2 = mem[rd_ptr][2];
  assign dout3 = mem[rd_ptr][3];

  // Queue storage, pointers, occupancy and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '{default: '0};
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= res_p;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (in_valid && !in_ready) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shiftrows_mixcols_ark.sv
// Bench for shiftrows_mixcols_ark: directed FIPS vectors plus random traffic
// checked against a byte-level AES round model and a scoreboard queue.
module tb_shiftrows_mixcols_ark;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        last_round;
  logic [31:0] cin0, cin1, cin2, cin3;
  logic [31:0] rkey0, rkey1, rkey2, rkey3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout0, dout1, dout2, dout3;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];
  logic         m_drop;

  shiftrows_mixcols_ark dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .last_round(last_round),
    .cin0(cin0), .cin1(cin1), .cin2(cin2), .cin3(cin3),
    .rkey0(rkey0), .rkey1(rkey1), .rkey2(rkey2), .rkey3(rkey3),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // State as 16 bytes, index = 4*column + row
  function automatic logic [127:0] ref_round(input logic [127:0] c, input logic [127:0] k,
                                             input logic lr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8];
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        t[4*col+row] = s[4*((col+row)%4)+row];
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        u[4*col+row] = lr ? t[4*col+row] :
          gmul(8'd2, t[4*col+row]) ^ gmul(8'd3, t[4*col+(row+1)%4]) ^
          t[4*col+(row+2)%4] ^ t[4*col+(row+3)%4];
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = u[i] ^ k[127-8*i -: 8];
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check pre-edge outputs vs model, clock, update model
  task automatic step(input logic iv, input logic lr, input logic [127:0] c,
                      input logic [127:0] k, input logic ordy);
    logic mpush, mpop;
    in_valid   = iv;
    last_round = lr;
    {cin0, cin1, cin2, cin3}     = c;
    {rkey0, rkey1, rkey2, rkey3} = k;
    out_ready  = ordy;
    check("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
    check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("dout_head", {dout0, dout1, dout2, dout3}, exp_q[0]);
    mpush = iv && (exp_q.size() < 2);
    mpop  = ordy && (exp_q.size() > 0);
    if (iv && exp_q.size() >= 2) m_drop = 1'b1;
    @(posedge clk);
    #1;
    if (mpop) void'(exp_q.pop_front());
    if (mpush) exp_q.push_back(ref_round(c, k, lr));
    check("drop_err", 128'(drop_err), 128'(m_drop));
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, '0, ordy);
  endtask

  initial begin
    logic [127:0] rc, rk;
    rst_n = 1'b0; in_valid = 1'b0; last_round = 1'b0; out_ready = 1'b0;
    {cin0, cin1, cin2, cin3} = '0; {rkey0, rkey1, rkey2, rkey3} = '0;
    m_drop = 1'b0;
    #12;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_drop_err", 128'(drop_err), 128'(0));
    check("reset_dout", {dout0, dout1, dout2, dout3}, 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 round 1
    step(1'b1, 1'b0, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230,
         128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0);
    check("fips_round1", {dout0, dout1, dout2, dout3},
          128'ha49c7ff2_689f352b_6b5bea43_026a5049);
    check("fips_valid", 128'(out_valid), 128'(1));
    idle(1'b1);

    // Final-round bypass
    step(1'b1, 1'b1, 128'h00010203_04050607_08090a0b_0c0d0e0f, '0, 1'b0);
    check("final_bypass", {dout0, dout1, dout2, dout3},
          128'h00050a0f_04090e03_080d0207_0c01060b);
    idle(1'b1);

    // MixColumns spot check
    step(1'b1, 1'b0, {4{32'hdb135345}}, '0, 1'b0);
    check("mixcol_spot", {dout0, dout1, dout2, dout3}, {4{32'h8e4da1bc}});
    idle(1'b1);

    // Backpressure: three offers, two accepted, third flagged
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    check("bp_in_ready_full", 128'(in_ready), 128'(0));
    check("bp_drop_set", 128'(drop_err), 128'(1));
    step(1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-operation clears queue and sticky flag without a clock edge
    step(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, '0, 1'b0);
    step(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, '0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_drop_err", 128'(drop_err), 128'(0));
    check("rst_dout", {dout0, dout1, dout2, dout3}, 128'(0));
    exp_q.delete();
    m_drop = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming: occupancy settles at one, never full
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      check("stream_in_ready", 128'(in_ready), 128'(1));
    end
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rc = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rc, rk,
           1'($urandom_range(0, 2) != 0));
    end
    idle(1'b1);
    idle(1'b1);
    check("final_empty", 128'(out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
